// File: rtl/read_return_collector_pkg.sv
// Shared types and defaults for the DDR2 read-return collector.
// Holds the tag and beat record layouts plus the size-code decoder.
package read_return_collector_pkg;

  typedef logic [1:0]  sz_t;
  typedef logic [24:0] addr_t;
  typedef logic [15:0] data_t;

  localparam int TAG_DEPTH_DEF  = 8;
  localparam int DATA_DEPTH_DEF = 32;

  typedef struct packed {
    sz_t   sz;
    addr_t addr;
  } tag_t;

  typedef struct packed {
    data_t data;
    addr_t addr;
    logic  last;
    logic  err;
  } beat_t;

  typedef enum logic {IDLE, COLLECT} state_t;

  // Burst length in beats: 8, 16, 24 or 32.
  function automatic logic [5:0] sz_to_beats(input sz_t sz);
    return (6'(sz) + 6'd1) << 3;
  endfunction

endpackage

// File: rtl/read_return_collector_sync_fifo.sv
// Synchronous FIFO with occupancy count; callers only read when non-empty
// and only write when not full or popping in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= next_ptr(wr_ptr);
      if (rd_en) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  // NOTE: the storage array has no reset; emptiness is carried by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/read_return_collector.sv
// Matches DDR2 read-return beats against queued request tags, checks each
// beat address and buffers beats for a ready/valid consumer.
module read_return_collector
  import read_return_collector_pkg::*;
#(
  parameter int TAG_DEPTH  = TAG_DEPTH_DEF,
  parameter int DATA_DEPTH = DATA_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_sz,
  input  logic [24:0] req_addr,
  input  logic [15:0] dout,
  input  logic [24:0] raddr,
  input  logic        validout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [24:0] rsp_addr,
  output logic        rsp_last,
  output logic        rsp_err,
  input  logic        clr_err,
  output logic        addr_err,
  output logic        unexpected_err,
  output logic        overflow_err,
  output logic [15:0] reads_done
);

  localparam int TCW = $clog2(TAG_DEPTH + 1);
  localparam int DCW = $clog2(DATA_DEPTH + 1);

  state_t         state;
  logic [4:0]     beat_idx;
  tag_t           tag_wr, tag_head;
  logic           tag_full, tag_empty;
  logic [TCW-1:0] tag_count;
  beat_t          beat_wr, beat_head;
  logic           data_full, data_empty;
  logic [DCW-1:0] unused_data_count;

  logic  tag_push, collecting, beat_in, beat_last, beat_bad;
  logic  data_push, data_pop, unexpected_evt, overflow_evt;
  addr_t exp_addr;
  logic [5:0] last_idx;

  assign req_ready = !tag_full;
  assign tag_push  = req_valid && !tag_full;
  assign tag_wr    = '{sz: req_sz, addr: req_addr};

  // Only COLLECT owns a head tag, so a request queued in the same cycle as a beat cannot claim it.
  assign collecting = (state == COLLECT);
  assign beat_in    = validout && collecting;
  assign exp_addr   = tag_head.addr + addr_t'(beat_idx);
  assign last_idx   = sz_to_beats(tag_head.sz) - 6'd1;
  assign beat_last  = beat_in && ({1'b0, beat_idx} == last_idx);
  assign beat_bad   = beat_in && (raddr != exp_addr);

  assign data_pop       = rsp_valid && rsp_ready;
  assign data_push      = beat_in && (!data_full || data_pop);
  assign overflow_evt   = beat_in && data_full && !data_pop;
  assign unexpected_evt = validout && !collecting;
  assign beat_wr        = '{data: dout, addr: raddr, last: beat_last, err: beat_bad};

  sync_fifo #(.WIDTH($bits(tag_t)), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (tag_push),
    .wr_data (tag_wr),
    .rd_en   (beat_last),
    .rd_data (tag_head),
    .full    (tag_full),
    .empty   (tag_empty),
    .count   (tag_count)
  );

  sync_fifo #(.WIDTH($bits(beat_t)), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (data_push),
    .wr_data (beat_wr),
    .rd_en   (data_pop),
    .rd_data (beat_head),
    .full    (data_full),
    .empty   (data_empty),
    .count   (unused_data_count)
  );

  // Outputs come straight from FIFO storage flops, forced to zero when nothing is held.
  assign rsp_valid = !data_empty;
  assign {rsp_data, rsp_addr, rsp_last, rsp_err} = data_empty ? '0 : beat_head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      beat_idx       <= '0;
      reads_done     <= '0;
      addr_err       <= 1'b0;
      unexpected_err <= 1'b0;
      overflow_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          beat_idx <= '0;
          if (!tag_empty) state <= COLLECT;
        end
        COLLECT: begin
          if (beat_in) begin
            if (beat_last) begin
              beat_idx <= '0;
              if (tag_count == TCW'(1) && !tag_push) state <= IDLE;
            end else begin
              beat_idx <= beat_idx + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (beat_last) reads_done <= reads_done + 16'd1;

      // A same-cycle error event beats clr_err.
      addr_err       <= (addr_err       && !clr_err) || beat_bad;
      unexpected_err <= (unexpected_err && !clr_err) || unexpected_evt;
      overflow_err   <= (overflow_err   && !clr_err) || overflow_evt;
    end
  end

endmodule

// File: doc/read_return_collector.md
READ_RETURN_COLLECTOR -- requirements
Module: read_return_collector

Interface
REQ-001 clk  in  1  system clock; all state updates on posedge clk.
REQ-002 reset  in  1  asynchronous, active-low reset.
REQ-003 req_valid  in  1  read-request issued to DDR2 controller this cycle (from driver side).
REQ-004 req_ready  out  1  tag queue can accept a request; req_ready = !tag_full.
REQ-005 req_sz  in  2  burst size code; beats = (req_sz+1)*8, i.e. 8/16/24/32.
REQ-006 req_addr  in  25  base address of the read.
REQ-007 dout  in  16  read data beat from controller DOUT.
REQ-008 raddr  in  25  address of beat from controller RADDR.
REQ-009 validout  in  1  beat valid from controller VALIDOUT; no backpressure possible.
REQ-010 rsp_valid  out  1  response beat available.
REQ-011 rsp_ready  in  1  consumer accepts beat when rsp_valid && rsp_ready.
REQ-012 rsp_data  out  16  beat data.
REQ-013 rsp_addr  out  25  beat address (as received).
REQ-014 rsp_last  out  1  final beat of a request.
REQ-015 rsp_err  out  1  this beat failed address check.
REQ-016 clr_err  in  1  one-cycle pulse clears sticky error flags.
REQ-017 addr_err, unexpected_err, overflow_err  out  1 each  sticky error flags.
REQ-018 reads_done  out  16  count of completed requests, wraps modulo 2^16.
REQ-019 Parameters: TAG_DEPTH default 8 (outstanding requests); DATA_DEPTH default 32 (beat FIFO entries).

Function
REQ-020 Tag FIFO SHALL store {req_sz, req_addr} on req_valid && req_ready; req_valid while full SHALL be ignored.
REQ-021 FSM SHALL have states IDLE and COLLECT; IDLE->COLLECT when tag FIFO non-empty; COLLECT->IDLE after last beat if tag FIFO would then be empty, else remain COLLECT with beat_idx=0.
REQ-022 In COLLECT each validout cycle SHALL increment beat_idx; expected address = head.addr + beat_idx, 25-bit modulo 2^25.
REQ-023 raddr != expected SHALL set rsp_err for that beat and set addr_err; beat still stored and counted.
REQ-024 Beat with beat_idx == beats-1 SHALL carry rsp_last=1, pop tag FIFO, increment reads_done in the same edge.
REQ-025 validout in IDLE (tag FIFO empty) SHALL set unexpected_err and discard the beat.
REQ-026 Beat arriving while beat FIFO full and no pop that cycle SHALL be dropped, set overflow_err, still advance beat_idx/tag logic.
REQ-027 Simultaneous push and pop on either FIFO SHALL be legal at any fill level, including full.
REQ-028 Latency: validout beat into empty beat FIFO SHALL give rsp_valid=1 on the next cycle; rsp_* outputs registered from FIFO head.
REQ-029 Request pushed in same cycle as first validout into empty tag FIFO SHALL NOT match that beat (beat is unexpected).
REQ-030 clr_err SHALL clear all sticky flags; an error event in the same cycle SHALL win (flag stays 1).

Reset
REQ-031 Reset assertion SHALL immediately force: state IDLE, both FIFOs empty, beat_idx=0, reads_done=0, all flags 0, rsp_valid=0, rsp_data/rsp_addr=0, rsp_last/rsp_err=0, req_ready=1.
REQ-032 Reset mid-burst SHALL discard partial burst; no beat delivered after release until new request.

Structure
REQ-033 Shared package (definitions.sv) SHALL hold ulogic types, TAG_DEPTH/DATA_DEPTH defaults, sz-to-beats function, tag struct {sz, addr}.
REQ-034 One parameterised sub-module sync_fifo (width, depth, full/empty) SHALL be instantiated twice.

Verification
REQ-035 sz=0, addr=0x0000100, 8 beats raddr 0x100..0x107 -> 8 rsp beats, rsp_last on 8th only, reads_done=1, no errors.
REQ-036 Two queued requests sz=1 @0x200, sz=3 @0x400, beats back-to-back -> 48 beats, rsp_last at beats 16 and 48, reads_done=2.
REQ-037 sz=0 @0x100, beat 3 raddr=0x105 -> only that beat rsp_err=1, addr_err=1, request completes; clr_err -> addr_err=0.
REQ-038 validout with no outstanding request -> unexpected_err=1, rsp_valid stays 0.
REQ-039 rsp_ready=0, sz=3 plus sz=0 (40 beats) -> 32 stored, overflow_err=1, reads_done=2; base 0x1FFFFFC sz=0 expects wrap to 0x0000003 with no addr_err.
REQ-040 reset asserted at beat 4 of sz=1 burst -> all outputs at reset values same cycle; new sz=0 request afterwards completes cleanly.
